seq_ctrl: RTL
=============

// Module: seq_ctrl
// PURPOSE
//  Parametrised successor to the accumulator-CPU control unit: multi-cycle fetch/operand/execute sequencer.
//  Drives the opcode/imm/acc/psr register strobes, the PC count/load and the RAM strobes.
//  Adds memory ready handshakes, conditional jumps on PSR flags, logic ops, HALT and illegal-opcode flagging.
// PARAMETERS
//  OPC_W    8  opcode / immediate byte width
//  PSR_W    4  status register width; bits [0]=Z [1]=N [2]=C [3]=V
//  ALUOP_W  3  ALU operation selector width
// PORTS
//  clk            in   1        clock, single domain
//  rst            in   1        synchronous reset, active-high
//  opcode         in   OPC_W    current instruction, from the opcode register
//  psr            in   PSR_W    program status register
//  imem_ready     in   1        instruction byte valid this cycle
//  dmem_ready     in   1        data memory access completes this cycle
//  opcode_update  out  1        load the opcode register from imem_data
//  imm_update     out  1        load the immediate register from imem_data
//  acc_update     out  1        load the ACC from the ALU result
//  psr_update     out  1        load the PSR from the APSR
//  alu_operation  out  ALUOP_W  ALU selector: PASS, ADD, SUB, AND, OR, XOR
//  pc_count       out  1        increment PC
//  pc_load        out  1        load PC from the immediate
//  ram_read       out  1        data read request, held until dmem_ready
//  ram_write      out  1        data write request, held until dmem_ready
//  halted         out  1        core stopped by HALT
//  illegal        out  1        1-cycle pulse: undefined opcode decoded
//  irq            in   1        interrupt request (SEQ_CTRL_IRQ_EN only)
//  irq_ack        out  1        interrupt taken pulse (SEQ_CTRL_IRQ_EN only)
//  pc_vec         out  1        with pc_load, PC loads the fixed vector (SEQ_CTRL_IRQ_EN only)
// BEHAVIOUR
//  States:
//   - FETCH -> OPERAND -> EXEC -> FETCH
//   - FETCH -> HALT (HALT opcode)
//   - IRQ (macro only)
//  Outputs are decoded combinationally from state/opcode/psr/ready; all are 0 while rst=1.
//  rst=1 at any edge, including mid-instruction or mid-memory-wait: state<=FETCH and the pending irq is cleared.
//  FETCH: waits for imem_ready=1. Then opcode_update=1 and pc_count=1; next state OPERAND, or HALT if the byte is HALT.
//   - HALT is decided from the imem byte, because opcode only updates at the edge.
//  OPERAND: waits for imem_ready=1. Then imm_update=1, pc_count=1; next state EXEC.
//  EXEC, by opcode:
//   - LOAD / ADD / SUB / AND / OR / XOR: ram_read=1 and alu_operation=op until dmem_ready=1.
//     In that ready cycle acc_update=1 and psr_update=1; next state FETCH.
//   - STORE: ram_write=1 until dmem_ready=1; PSR unchanged; next state FETCH.
//   - JUMP: pc_load=1. JZ/JN/JC: pc_load=psr[0]/psr[1]/psr[2]. All take 1 cycle.
//   - NOP: 1 cycle, no strobes.
//   - Undefined opcode: illegal=1 for 1 cycle, otherwise behaves as NOP.
//  Latency with ready tied high: 3 cycles per instruction; each ready=0 cycle adds 1 cycle of wait.
//  ram_read and ram_write are never both 1. pc_count and pc_load are never both 1.
//  HALT: halted=1, no other strobes; left only by reset (or by IRQ when compiled in).
// CONFIGURATION
//  SEQ_CTRL_IRQ_EN defined:
//   - irq, irq_ack and pc_vec ports exist.
//   - A rising edge of irq sets pending; pending is taken at an instruction boundary (EXEC completion) or in HALT.
//   - IRQ state, 1 cycle: pc_load=1, pc_vec=1, irq_ack=1, pending cleared, halted=0; next state FETCH.
//   - irq held high does not retrigger.
//  SEQ_CTRL_IRQ_EN undefined: these ports are absent and no IRQ state exists.
// STRUCTURE
//  defs.v (shared) holds:
//   - MCU_* opcode encodings: existing LOAD/ADD/SUB/JUMP/STORE plus new AND/OR/XOR/JZ/JN/JC/NOP/HALT.
//   - ALUOP_* encodings, PSR bit indices and state encodings.
//  Sub-module seq_ctrl_dec: combinational opcode -> {class, alu_op, cond_sel, legal}; the FSM lives in seq_ctrl.
// TESTING
//  1. Readies=1, stream LOAD,0xAE: opcode_update@c1, imm_update@c2, ram_read+acc_update+psr_update@c3, alu_op=PASS.
//  2. ADD with dmem_ready low for 2 cycles: ram_read held 3 cycles; acc_update only in the ready cycle; 5 cycles total.
//  3. JZ,0x40: psr=4'b0001 -> pc_load@EXEC; psr=4'b0000 -> pc_load=0 and PC continues counting.
//  4. STORE,0x10 then imem_ready=0 for 2 cycles at FETCH: ram_write 1 cycle; opcode_update only once ready=1.
//  5. HALT: halted=1 and all strobes 0 for 10 cycles; rst pulse -> FETCH, halted=0; rst during EXEC wait aborts ram_read.
//  6. (IRQ_EN) irq rises mid-ADD: ADD completes, then irq_ack+pc_load+pc_vec 1 cycle; also wakes from HALT.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared encodings for the sequencer: opcodes, ALU selectors, PSR bit indices,
// FSM state codes and the decoded instruction class.
package seq_ctrl_pkg;

    localparam int OPC_W_DEF   = 8;
    localparam int PSR_W_DEF   = 4;
    localparam int ALUOP_W_DEF = 3;

    localparam logic [7:0] MCU_NOP   = 8'h00;
    localparam logic [7:0] MCU_LOAD  = 8'h01;
    localparam logic [7:0] MCU_ADD   = 8'h02;
    localparam logic [7:0] MCU_SUB   = 8'h03;
    localparam logic [7:0] MCU_JUMP  = 8'h04;
    localparam logic [7:0] MCU_STORE = 8'h05;
    localparam logic [7:0] MCU_AND   = 8'h06;
    localparam logic [7:0] MCU_OR    = 8'h07;
    localparam logic [7:0] MCU_XOR   = 8'h08;
    localparam logic [7:0] MCU_JZ    = 8'h09;
    localparam logic [7:0] MCU_JN    = 8'h0A;
    localparam logic [7:0] MCU_JC    = 8'h0B;
    localparam logic [7:0] MCU_HALT  = 8'hFF;

    localparam logic [2:0] ALUOP_PASS = 3'd0;
    localparam logic [2:0] ALUOP_ADD  = 3'd1;
    localparam logic [2:0] ALUOP_SUB  = 3'd2;
    localparam logic [2:0] ALUOP_AND  = 3'd3;
    localparam logic [2:0] ALUOP_OR   = 3'd4;
    localparam logic [2:0] ALUOP_XOR  = 3'd5;

    localparam int PSR_Z = 0;
    localparam int PSR_N = 1;
    localparam int PSR_C = 2;
    localparam int PSR_V = 3;

    localparam logic [2:0] ST_FETCH   = 3'd0;
    localparam logic [2:0] ST_OPERAND = 3'd1;
    localparam logic [2:0] ST_EXEC    = 3'd2;
    localparam logic [2:0] ST_HALT    = 3'd3;
    localparam logic [2:0] ST_IRQ     = 3'd4;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_STORE,
        CLS_JUMP,
        CLS_COND
    } instr_class_e;

endpackage

// File: rtl/seq_ctrl_dec.sv
// Combinational opcode decoder: instruction class, ALU selector, PSR flag
// used by conditional jumps, and a legal-opcode flag.
module seq_ctrl_dec
    import seq_ctrl_pkg::*;
#(
    parameter int OPC_W   = OPC_W_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF
) (
    input  logic [OPC_W-1:0]   opcode,
    output instr_class_e       cls,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         cond_sel,
    output logic               legal
);

    always_comb begin
        cls      = CLS_NOP;
        alu_op   = ALUOP_W'(ALUOP_PASS);
        cond_sel = 2'(PSR_Z);
        legal    = 1'b1;
        case (opcode)
            OPC_W'(MCU_LOAD):  cls = CLS_ALU;
            OPC_W'(MCU_ADD):   begin cls = CLS_ALU; alu_op = ALUOP_W'(ALUOP_ADD); end
            OPC_W'(MCU_SUB):   begin cls = CLS_ALU; alu_op = ALUOP_W'(ALUOP_SUB); end
            OPC_W'(MCU_AND):   begin cls = CLS_ALU; alu_op = ALUOP_W'(ALUOP_AND); end
            OPC_W'(MCU_OR):    begin cls = CLS_ALU; alu_op = ALUOP_W'(ALUOP_OR);  end
            OPC_W'(MCU_XOR):   begin cls = CLS_ALU; alu_op = ALUOP_W'(ALUOP_XOR); end
            OPC_W'(MCU_STORE): cls = CLS_STORE;
            OPC_W'(MCU_JUMP):  cls = CLS_JUMP;
            OPC_W'(MCU_JZ):    begin cls = CLS_COND; cond_sel = 2'(PSR_Z); end
            OPC_W'(MCU_JN):    begin cls = CLS_COND; cond_sel = 2'(PSR_N); end
            OPC_W'(MCU_JC):    begin cls = CLS_COND; cond_sel = 2'(PSR_C); end
            // HALT never reaches EXEC in normal flow; treat it as a NOP if it does.
            OPC_W'(MCU_NOP), OPC_W'(MCU_HALT): cls = CLS_NOP;
            default:           legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle fetch/operand/execute sequencer for the accumulator CPU.
// Optional interrupt entry is compiled in with SEQ_CTRL_IRQ_EN.
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int OPC_W   = OPC_W_DEF,
    parameter int PSR_W   = PSR_W_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [OPC_W-1:0]   imem_data,
    input  logic [PSR_W-1:0]   psr,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               opcode_update,
    output logic               imm_update,
    output logic               acc_update,
    output logic               psr_update,
    output logic [ALUOP_W-1:0] alu_operation,
    output logic               pc_count,
    output logic               pc_load,
    output logic               ram_read,
    output logic               ram_write,
    output logic               halted,
`ifdef SEQ_CTRL_IRQ_EN
    input  logic               irq,
    output logic               irq_ack,
    output logic               pc_vec,
`endif
    output logic               illegal
);

    logic [2:0]         state_q, state_d;
    instr_class_e       cls;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         cond_sel;
    logic               legal;
    logic               exec_done;

    seq_ctrl_dec #(
        .OPC_W   (OPC_W),
        .ALUOP_W (ALUOP_W)
    ) u_dec (
        .opcode   (opcode),
        .cls      (cls),
        .alu_op   (alu_op),
        .cond_sel (cond_sel),
        .legal    (legal)
    );

`ifdef SEQ_CTRL_IRQ_EN
    logic irq_prev_q, irq_prev_d;
    logic pending_q, pending_d;

    // Edge-detect irq so a held level requests only one entry.
    always_comb begin
        irq_prev_d = irq;
        pending_d  = (pending_q && (state_q != ST_IRQ)) || (irq && !irq_prev_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev_q <= irq_prev_d;
            pending_q  <= 1'b0;
        end else begin
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        exec_done     = 1'b0;
        opcode_update = 1'b0;
        imm_update    = 1'b0;
        acc_update    = 1'b0;
        psr_update    = 1'b0;
        alu_operation = ALUOP_W'(ALUOP_PASS);
        pc_count      = 1'b0;
        pc_load       = 1'b0;
        ram_read      = 1'b0;
        ram_write     = 1'b0;
        halted        = 1'b0;
        illegal       = 1'b0;
`ifdef SEQ_CTRL_IRQ_EN
        irq_ack       = 1'b0;
        pc_vec        = 1'b0;
`endif
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    opcode_update = 1'b1;
                    pc_count      = 1'b1;
                    // The opcode register only updates at the edge, so HALT is seen on the bus.
                    state_d = (imem_data == OPC_W'(MCU_HALT)) ? ST_HALT : ST_OPERAND;
                end
            end
            ST_OPERAND: begin
                if (imem_ready) begin
                    imm_update = 1'b1;
                    pc_count   = 1'b1;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls)
                    CLS_ALU: begin
                        ram_read      = 1'b1;
                        alu_operation = alu_op;
                        if (dmem_ready) begin
                            acc_update = 1'b1;
                            psr_update = 1'b1;
                            exec_done  = 1'b1;
                        end
                    end
                    CLS_STORE: begin
                        ram_write = 1'b1;
                        exec_done = dmem_ready;
                    end
                    CLS_JUMP: begin
                        pc_load   = 1'b1;
                        exec_done = 1'b1;
                    end
                    CLS_COND: begin
                        pc_load   = psr[cond_sel];
                        exec_done = 1'b1;
                    end
                    default: begin
                        illegal   = !legal;
                        exec_done = 1'b1;
                    end
                endcase
                if (exec_done) begin
`ifdef SEQ_CTRL_IRQ_EN
                    state_d = pending_q ? ST_IRQ : ST_FETCH;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_HALT: begin
                halted = 1'b1;
`ifdef SEQ_CTRL_IRQ_EN
                if (pending_q) state_d = ST_IRQ;
`endif
            end
`ifdef SEQ_CTRL_IRQ_EN
            ST_IRQ: begin
                pc_load = 1'b1;
                pc_vec  = 1'b1;
                irq_ack = 1'b1;
                state_d = ST_FETCH;
            end
`endif
            default: state_d = ST_FETCH;
        endcase
        if (rst) begin
            state_d       = ST_FETCH;
            opcode_update = 1'b0;
            imm_update    = 1'b0;
            acc_update    = 1'b0;
            psr_update    = 1'b0;
            alu_operation = ALUOP_W'(ALUOP_PASS);
            pc_count      = 1'b0;
            pc_load       = 1'b0;
            ram_read      = 1'b0;
            ram_write     = 1'b0;
            halted        = 1'b0;
            illegal       = 1'b0;
`ifdef SEQ_CTRL_IRQ_EN
            irq_ack       = 1'b0;
            pc_vec        = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

endmodule
